// File: rtl/rega_sequencer_pkg.sv
// Shared definitions for the irrigation-cycle controller: state codes and default durations.
package rega_sequencer_pkg;

    localparam int CNT_W_DEF   = 3;
    localparam int T_ASP_DEF   = 5;
    localparam int T_GOT_DEF   = 3;
    localparam int T_PAUSA_DEF = 2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CARGA    = 3'd1,
        ST_REGA     = 3'd2,
        ST_DESCANSO = 3'd3,
        ST_ALARME   = 3'd4
    } st_t;

endpackage

// File: rtl/rega_sequencer_if.sv
// Sensor/actuator bundle of the irrigation controller; Manual exists only with REGA_MANUAL_EN.
interface rega_sequencer_if
    import rega_sequencer_pkg::*;
    #(parameter int CNT_W = CNT_W_DEF);

    logic             Seco;
    logic             NivelBaixo;
    logic             Modo;
`ifdef REGA_MANUAL_EN
    logic             Manual;
`endif
    logic             Valvula;
    logic             Bomba;
    logic             Alarme;
    logic             Fim;
    logic [2:0]       Estado;
    logic [CNT_W-1:0] Cont;

`ifdef REGA_MANUAL_EN
    modport master (output Seco, NivelBaixo, Modo, Manual,
                    input  Valvula, Bomba, Alarme, Fim, Estado, Cont);
    modport slave  (input  Seco, NivelBaixo, Modo, Manual,
                    output Valvula, Bomba, Alarme, Fim, Estado, Cont);
`else
    modport master (output Seco, NivelBaixo, Modo,
                    input  Valvula, Bomba, Alarme, Fim, Estado, Cont);
    modport slave  (input  Seco, NivelBaixo, Modo,
                    output Valvula, Bomba, Alarme, Fim, Estado, Cont);
`endif

endinterface

// File: rtl/rega_sequencer_timer.sv
// Loadable down-counter for the watering/pause durations; holds at zero instead of wrapping.
module rega_sequencer_timer #(
    parameter int CNT_W = 3
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Load,
    input  logic [CNT_W-1:0] Val,
    input  logic             En,
    output logic [CNT_W-1:0] Q,
    output logic             Zero
);

    assign Zero = (Q == '0);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            Q <= '0;
        end else if (Load) begin
            Q <= Val;
        end else if (En && !Zero) begin
            Q <= Q - 1'b1;
        end
    end

endmodule

// File: rtl/rega_sequencer.sv
// Irrigation-cycle sequencer: IDLE -> CARGA -> REGA -> DESCANSO, with tank-low ALARME override.
// Optional REGA_MANUAL_EN adds a Manual start input that behaves like Seco in IDLE.
module rega_sequencer
    import rega_sequencer_pkg::*;
    #(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int T_ASP   = T_ASP_DEF,
    parameter int T_GOT   = T_GOT_DEF,
    parameter int T_PAUSA = T_PAUSA_DEF
) (
    input  logic           Clk,
    input  logic           Rst,
    rega_sequencer_if.slave bus
);

    st_t              state, nxt;
    logic             modo_l;
    logic             start;
    logic             ld, en, zero;
    logic [CNT_W-1:0] ld_val, q;
    logic             valvula, bomba, alarme, fim;

`ifdef REGA_MANUAL_EN
    assign start = bus.Seco | bus.Manual;
`else
    assign start = bus.Seco;
`endif

    // Next state and timer control; every path into ALARME clears the timer.
    always_comb begin
        nxt    = state;
        ld     = 1'b0;
        en     = 1'b0;
        ld_val = '0;
        case (state)
            ST_IDLE: begin
                if (bus.NivelBaixo)  nxt = ST_ALARME;
                else if (start)      nxt = ST_CARGA;
            end
            ST_CARGA: begin
                ld = 1'b1;
                if (bus.NivelBaixo) begin
                    nxt = ST_ALARME;
                end else begin
                    nxt    = ST_REGA;
                    ld_val = bus.Modo ? CNT_W'(T_ASP) : CNT_W'(T_GOT);
                end
            end
            ST_REGA: begin
                if (bus.NivelBaixo) begin
                    nxt = ST_ALARME;
                    ld  = 1'b1;
                end else if (!zero) begin
                    en = 1'b1;
                end else begin
                    nxt    = ST_DESCANSO;
                    ld     = 1'b1;
                    ld_val = CNT_W'(T_PAUSA);
                end
            end
            ST_DESCANSO: begin
                if (bus.NivelBaixo) begin
                    nxt = ST_ALARME;
                    ld  = 1'b1;
                end else if (!zero) begin
                    en = 1'b1;
                end else begin
                    nxt = ST_IDLE;
                end
            end
            ST_ALARME: begin
                ld = 1'b1;
                if (!bus.NivelBaixo) nxt = ST_IDLE;
            end
            default: begin
                ld  = 1'b1;
                nxt = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they track Estado exactly.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state   <= ST_IDLE;
            modo_l  <= 1'b0;
            valvula <= 1'b0;
            bomba   <= 1'b0;
            alarme  <= 1'b0;
            fim     <= 1'b0;
        end else begin
            state   <= nxt;
            if (state == ST_CARGA) modo_l <= bus.Modo;
            valvula <= (nxt == ST_REGA);
            bomba   <= (nxt == ST_REGA) && ((state == ST_CARGA) ? bus.Modo : modo_l);
            alarme  <= (nxt == ST_ALARME);
            fim     <= (state == ST_REGA) && (nxt == ST_DESCANSO);
        end
    end

    rega_sequencer_timer #(.CNT_W(CNT_W)) u_timer (
        .Clk  (Clk),
        .Rst  (Rst),
        .Load (ld),
        .Val  (ld_val),
        .En   (en),
        .Q    (q),
        .Zero (zero)
    );

    assign bus.Valvula = valvula;
    assign bus.Bomba   = bomba;
    assign bus.Alarme  = alarme;
    assign bus.Fim     = fim;
    assign bus.Estado  = state;
    assign bus.Cont    = q;

endmodule
